// File: rtl/vga_vram_ctl.sv
// vga_vram_ctl: arbitrates video-refresh and CPU accesses onto one 32-bit asynchronous SRAM
module vga_vram_ctl #(
    parameter int SRAM_CYCLES = 2,
    parameter int HOLDOFF     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [31:0] vid_data,
    output logic        vid_ready,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [14:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic [14:0] sram_addr,
    output logic [31:0] sram_dout,
    input  logic [31:0] sram_din,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, VRD, CRD, CWR, HOLD} state_t;

    localparam logic [3:0] CNT_INIT  = 4'(SRAM_CYCLES - 1);
    localparam logic [1:0] HOLD_INIT = 2'(HOLDOFF - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [1:0]  hcnt, hcnt_n;
    logic [31:0] vid_data_n, cpu_rdata_n, sram_dout_n;
    logic [14:0] sram_addr_n;
    logic        vid_ready_n, cpu_ack_n, ce_n_n, oe_n_n, we_n_n;

    // State and every output are registered; reset forces pins inactive immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            vid_data  <= '0;
            cpu_rdata <= '0;
            vid_ready <= 1'b0;
            cpu_ack   <= 1'b0;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hcnt      <= hcnt_n;
            vid_data  <= vid_data_n;
            cpu_rdata <= cpu_rdata_n;
            vid_ready <= vid_ready_n;
            cpu_ack   <= cpu_ack_n;
            sram_addr <= sram_addr_n;
            sram_dout <= sram_dout_n;
            sram_ce_n <= ce_n_n;
            sram_oe_n <= oe_n_n;
            sram_we_n <= we_n_n;
            busy      <= state_n != IDLE;
        end
    end

    // Next-state logic: video wins arbitration in IDLE, HOLD masks requests while requesters drop
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hcnt_n      = hcnt;
        vid_data_n  = vid_data;
        cpu_rdata_n = cpu_rdata;
        vid_ready_n = 1'b0;
        cpu_ack_n   = 1'b0;
        sram_addr_n = sram_addr;
        sram_dout_n = sram_dout;
        ce_n_n      = sram_ce_n;
        oe_n_n      = sram_oe_n;
        we_n_n      = sram_we_n;
        case (state)
            IDLE: begin
                if (vid_req || cpu_req) begin
                    cnt_n       = CNT_INIT;
                    ce_n_n      = 1'b0;
                    sram_addr_n = vid_req ? vid_addr : cpu_addr;
                    if (vid_req || !cpu_write) begin
                        state_n = vid_req ? VRD : CRD;
                        oe_n_n  = 1'b0;
                    end else begin
                        state_n     = CWR;
                        sram_dout_n = cpu_wdata;
                        we_n_n      = 1'b0;
                    end
                end
            end
            VRD, CRD: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    vid_data_n  = (state == VRD) ? sram_din : vid_data;
                    cpu_rdata_n = (state == CRD) ? sram_din : cpu_rdata;
                    vid_ready_n = state == VRD;
                    cpu_ack_n   = state == CRD;
                    ce_n_n      = 1'b1;
                    oe_n_n      = 1'b1;
                    hcnt_n      = HOLD_INIT;
                    state_n     = HOLD;
                end
            end
            CWR: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    cpu_ack_n = 1'b1;
                    ce_n_n    = 1'b1;
                    we_n_n    = 1'b1;
                    hcnt_n    = HOLD_INIT;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                if (hcnt == 2'd0) state_n = IDLE;
                else hcnt_n = hcnt - 2'd1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
